// File: rtl/register_file_param_pkg.sv
// -----------------------------------------------------------------------------
// register_file_param_pkg
// Shared definitions for the parametrised register file:
//   - rfState_e      : clear-engine state (IDLE, CLEAR)
//   - rfClog2        : address-width helper usable in parameter lists
//   - RF_DEFAULT_*   : default geometry (8 x 8-bit)
// -----------------------------------------------------------------------------
package register_file_param_pkg;

    localparam int RF_DEFAULT_WIDTH = 8;
    localparam int RF_DEFAULT_DEPTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rfState_e;

    // Ceiling log2. A depth of 1 still yields 0, but the register file
    // requires DEPTH >= 2, so the address is always at least one bit wide.
    function automatic int rfClog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/register_file_param_rf_clear_ctrl.sv
// -----------------------------------------------------------------------------
// rf_clear_ctrl
// Clear-sweep controller for register_file_param.
//   clk, rstN : rising-edge clock, asynchronous active-low reset
//   clrReq    : one-cycle clear-all request (ignored while sweeping)
//   wen       : raw write enable, used only to flag rejected writes
//   wrGate    : high when a write may reach the array (IDLE only)
//   clrEn     : high while a sweep write of zero is due this edge
//   clrIdx    : index being zeroed on this edge
//   busy      : sweep in progress
//   wrDrop    : registered pulse, a write arrived while sweeping
// -----------------------------------------------------------------------------
module rf_clear_ctrl
    import register_file_param_pkg::*;
#(
    parameter int DEPTH    = RF_DEFAULT_DEPTH,
    parameter int ZERO_REG = 1,
    localparam int AW      = rfClog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          clrReq,
    input  logic          wen,
    output logic          wrGate,
    output logic          clrEn,
    output logic [AW-1:0] clrIdx,
    output logic          busy,
    output logic          wrDrop
);

    // Register 0 never holds data when it is hardwired, so the sweep skips it.
    localparam logic [AW-1:0] FIRST_IDX = (ZERO_REG != 0) ? AW'(1) : AW'(0);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    rfState_e      state;
    rfState_e      stateNext;
    logic [AW-1:0] sweepCnt;
    logic [AW-1:0] sweepCntNext;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            sweepCnt <= '0;
            wrDrop   <= 1'b0;
        end else begin
            state    <= stateNext;
            sweepCnt <= sweepCntNext;
            wrDrop   <= (state == CLEAR) && wen;
        end
    end

    always_comb begin
        stateNext    = state;
        sweepCntNext = sweepCnt;
        wrGate       = 1'b0;
        clrEn        = 1'b0;
        unique case (state)
            IDLE: begin
                wrGate = 1'b1;
                if (clrReq) begin
                    stateNext    = CLEAR;
                    sweepCntNext = FIRST_IDX;
                end
            end
            CLEAR: begin
                clrEn = 1'b1;
                // Terminal detection stops the counter at the last index
                // instead of letting it wrap back into the array.
                if (sweepCnt == LAST_IDX) begin
                    stateNext    = IDLE;
                    sweepCntNext = '0;
                end else begin
                    sweepCntNext = sweepCnt + AW'(1);
                end
            end
            default: begin
                stateNext    = IDLE;
                sweepCntNext = '0;
            end
        endcase
    end

    assign clrIdx = sweepCnt;
    assign busy   = (state == CLEAR);

endmodule

// File: rtl/register_file_param.sv
// -----------------------------------------------------------------------------
// register_file_param
// WIDTH x DEPTH general-purpose register bank, one write port, two
// combinational read ports, optional hardwired-zero register 0, optional
// write-to-read bypass and a sequential clear-all engine.
//   Clk, Rst_n     : rising-edge clock, asynchronous active-low reset
//   WEN, RW, busW  : write enable / address / data
//   RX, busX       : read port X address / data
//   RY, busY       : read port Y address / data
//   CLR            : one-cycle clear-all request
//   busy           : clear sweep running
//   wr_drop        : one-cycle pulse, a write was rejected during a sweep
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module register_file_param
    import register_file_param_pkg::*;
#(
    parameter int WIDTH    = RF_DEFAULT_WIDTH,
    parameter int DEPTH    = RF_DEFAULT_DEPTH,
    parameter int BYPASS   = 0,
    parameter int ZERO_REG = 1,
    localparam int AW      = rfClog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             WEN,
    input  logic [AW-1:0]    RW,
    input  logic [WIDTH-1:0] busW,
    input  logic [AW-1:0]    RX,
    input  logic [AW-1:0]    RY,
    output logic [WIDTH-1:0] busX,
    output logic [WIDTH-1:0] busY,
    input  logic             CLR,
    output logic             busy,
    output logic             wr_drop
);

    logic [WIDTH-1:0] regs [DEPTH];

    logic          wrGate;
    logic          clrEn;
    logic [AW-1:0] clrIdx;
    logic          wrEn;
    logic          rwIsZeroReg;

    rf_clear_ctrl #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) uClearCtrl (
        .clk    (Clk),
        .rstN   (Rst_n),
        .clrReq (CLR),
        .wen    (WEN),
        .wrGate (wrGate),
        .clrEn  (clrEn),
        .clrIdx (clrIdx),
        .busy   (busy),
        .wrDrop (wr_drop)
    );

    assign rwIsZeroReg = (ZERO_REG != 0) && (RW == '0);

    // An accepted write: IDLE only, never to a hardwired register 0. The same
    // qualifier gates the bypass, so a dropped write is never forwarded.
    assign wrEn = WEN && wrGate && !rwIsZeroReg;

    // wrEn and clrEn are mutually exclusive (IDLE vs CLEAR), so at most one
    // entry is updated per edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wrEn) begin
                regs[RW] <= busW;
            end
            if (clrEn) begin
                regs[clrIdx] <= '0;
            end
        end
    end

    // Zero-register override is applied last so it wins over the bypass.
    always_comb begin
        busX = regs[RX];
        if ((BYPASS != 0) && wrEn && (RX == RW)) begin
            busX = busW;
        end
        if ((ZERO_REG != 0) && (RX == '0)) begin
            busX = '0;
        end
    end

    always_comb begin
        busY = regs[RY];
        if ((BYPASS != 0) && wrEn && (RY == RW)) begin
            busY = busW;
        end
        if ((ZERO_REG != 0) && (RY == '0)) begin
            busY = '0;
        end
    end

endmodule
